fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the team's FIFO buffers.
//   Adds configurable width/depth, almost-full/almost-empty thresholds, a fill count,
//   sticky overflow/underflow error flags, synchronous flush and a selectable
//   first-word-fall-through (FWFT) read mode. Used between same-clock producer/consumer stages.
// PARAMETERS
//   DSIZE     8   data word width in bits
//   ASIZE     4   address width; depth DEPTH = 2**ASIZE entries
//   AF_LEVEL  14  almost_full asserts when fill_count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  2   almost_empty asserts when fill_count <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0   0 = registered read (1-cycle latency); 1 = head word shown on d_output
// PORTS
//   clk           in   1        single clock, all state on rising edge
//   rst           in   1        asynchronous, active-low reset
//   wr_inc        in   1        write request; d_input stored if accepted
//   d_input       in   DSIZE    write data
//   rd_inc        in   1        read request; pops head word if accepted
//   d_output      out  DSIZE    read data
//   flush         in   1        synchronous clear of contents
//   clr_err       in   1        clears sticky overflow/underflow
//   wr_full       out  1        fill_count == DEPTH
//   rd_empty      out  1        fill_count == 0
//   almost_full   out  1        fill_count >= AF_LEVEL
//   almost_empty  out  1        fill_count <= AE_LEVEL
//   fill_count    out  ASIZE+1  words currently stored (0..DEPTH)
//   overflow      out  1        sticky: write attempted while full
//   underflow     out  1        sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (rst=0, async): wptr/rptr/fill_count=0, d_output=0, rd_empty=1, almost_empty=1,
//     wr_full=0, almost_full=0, overflow=0, underflow=0. Storage array not reset.
//   - Pointers ASIZE bits, wrap DEPTH-1 -> 0; fill_count is a registered counter; all
//     flags decoded from registered fill_count (no comb path from wr_inc/rd_inc to flags).
//   - Write accepted = wr_inc & !wr_full; read accepted = rd_inc & !rd_empty. Evaluated on
//     current-cycle flags: when full, a simultaneous read is accepted but the write is
//     rejected; when empty, a simultaneous write is accepted but the read is rejected.
//   - Both accepted: fill_count unchanged, both pointers advance.
//   - FWFT=0: d_output registered; updates to mem[rptr] on edge of accepted read, else holds.
//   - FWFT=1: d_output = mem[rptr] combinationally while !rd_empty (value when empty is
//     don't-care); word written to empty FIFO visible the cycle after the write edge.
//   - overflow set on wr_inc & wr_full; underflow set on rd_inc & rd_empty; cleared by
//     clr_err; set wins over clr_err in the same cycle.
//   - flush: next edge pointers and fill_count -> 0; has priority over wr_inc/rd_inc in
//     that cycle (both ignored, no error flags set); d_output (FWFT=0) holds last value.
//   - Reset mid-operation discards all contents immediately; no partial state survives.
// TESTING (DSIZE=8, ASIZE=4, AF_LEVEL=14, AE_LEVEL=2; run FWFT=0 and FWFT=1)
//   1 Fill: 16 writes 0x00..0x0F -> almost_empty drops at count 3, almost_full at 14,
//     wr_full after 16th edge, fill_count=16; 17th write 0xAA dropped, overflow=1.
//   2 Drain: 16 reads -> 0x00..0x0F in order (FWFT=0: one cycle after each accepted read);
//     rd_empty after 16th; 17th read -> underflow=1, d_output holds 0x0F (FWFT=0).
//   3 Steady state: pre-load 8, then wr_inc=rd_inc=1 for 20 cycles with incrementing data
//     -> fill_count stays 8, pointers wrap, read sequence matches write order exactly.
//   4 Full+both: at count 16 assert wr_inc/rd_inc one cycle -> count 15, overflow=1, head
//     popped; clr_err alone next cycle -> overflow=0; clr_err with wr_inc while full -> stays 1.
//   5 Flush: count 9, flush=1 with wr_inc=1 -> next edge count 0, rd_empty=1, no overflow;
//     subsequent write 0x5A read back as 0x5A.
//   6 Reset mid-op: count 9, drop rst between edges -> outputs at reset values immediately;
//     release rst, write 0x33 -> read returns 0x33, fill_count returns to 0.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags, sticky
// error flags, synchronous flush and selectable first-word-fall-through reads.
module fifo_sync_param #(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned ASIZE    = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_inc,
  input  logic [DSIZE-1:0] d_input,
  input  logic             rd_inc,
  output logic [DSIZE-1:0] d_output,
  input  logic             flush,
  input  logic             clr_err,
  output logic             wr_full,
  output logic             rd_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   fill_count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned CW    = ASIZE + 1;

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DSIZE-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Flags decode only the registered count, so requests never reach them combinationally.
  assign wr_full      = (count_q == CW'(DEPTH));
  assign rd_empty     = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fill_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Next-state for pointers, count, read register and sticky errors; flush overrides requests.
  always_comb begin
    wr_acc  = wr_inc & ~wr_full & ~flush;
    rd_acc  = rd_inc & ~rd_empty & ~flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = (ovf_q & ~clr_err) | (wr_inc & wr_full & ~flush);
    unf_d   = (unf_q & ~clr_err) | (rd_inc & rd_empty & ~flush);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ASIZE'(1);
      if (rd_acc) begin
        rptr_d = rptr_q + ASIZE'(1);
        dout_d = mem_q[rptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= d_input;
  end

  // Read data: registered pop result, or the live head word in FWFT mode.
  always_comb begin
    if (FWFT != 0) d_output = rd_empty ? '0 : mem_q[rptr_q];
    else           d_output = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param; drives a registered-read and an FWFT
// instance with the same stimulus and checks both against a vector table.
module tb_fifo_sync_param;

  typedef struct {
    bit        wr;
    bit        rd;
    bit        fl;
    bit        clr;
    logic [7:0] din;
    int        cnt;
    bit        ovf;
    bit        unf;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_inc, rd_inc, flush, clr_err;
  logic [7:0] d_input;
  logic [7:0] dout   [2];
  logic       full   [2];
  logic       empty  [2];
  logic       afull  [2];
  logic       aempty [2];
  logic [4:0] cnt    [2];
  logic       ovf    [2];
  logic       unf    [2];

  int tests  = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fifo_sync_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr_inc(wr_inc), .d_input(d_input), .rd_inc(rd_inc),
    .d_output(dout[0]), .flush(flush), .clr_err(clr_err), .wr_full(full[0]),
    .rd_empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
    .fill_count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0]));

  fifo_sync_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr_inc(wr_inc), .d_input(d_input), .rd_inc(rd_inc),
    .d_output(dout[1]), .flush(flush), .clr_err(clr_err), .wr_full(full[1]),
    .rd_empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
    .fill_count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1]));

  task automatic check(input string name, input int idx, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  function automatic void add(bit wr, bit rd, bit fl, bit clr, logic [7:0] din,
                              int c, bit o, bit u, logic [7:0] d0, logic [7:0] d1);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
    v.cnt = c; v.ovf = o; v.unf = u; v.d0 = d0; v.d1 = d1;
    vecs.push_back(v);
  endfunction

  // Compare both instances against the expected count, flags, errors and data.
  task automatic check_state(input string tag, input int idx, input int c, input bit o,
                             input bit u, input logic [7:0] d0, input logic [7:0] d1);
    int exp_flags;
    exp_flags = {28'd0, (c == 16), (c == 0), (c >= 14), (c <= 2)};
    for (int k = 0; k < 2; k++) begin
      check({tag, "_count"}, idx, int'(cnt[k]), c);
      check({tag, "_flags"}, idx, int'({full[k], empty[k], afull[k], aempty[k]}), exp_flags);
      check({tag, "_ovf"},   idx, int'(ovf[k]), int'(o));
      check({tag, "_unf"},   idx, int'(unf[k]), int'(u));
    end
    check({tag, "_dout_reg"}, idx, int'(dout[0]), int'(d0));
    if (c != 0) check({tag, "_dout_fwft"}, idx, int'(dout[1]), int'(d1));
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    wr_inc = v.wr; rd_inc = v.rd; flush = v.fl; clr_err = v.clr; d_input = v.din;
    @(posedge clk);
    #1;
    check_state(tag, idx, v.cnt, v.ovf, v.unf, v.d0, v.d1);
  endtask

  initial begin
    vec_t v;
    // Fill: 0x00..0x0F, then a dropped 17th write.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'(i), i + 1, 0, 0, 8'h00, 8'h00);
    add(1, 0, 0, 0, 8'hAA, 16, 1, 0, 8'h00, 8'h00);
    // Drain in order, then one read too many, then clear errors.
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'h00, 15 - i, 1, 0, 8'(i), 8'(i + 1));
    add(0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h0F, 8'h00);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h0F, 8'h00);
    // Steady state: preload 8, 20 simultaneous read/write cycles, drain 8.
    for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 8'(8'h10 + i), i + 1, 0, 0, 8'h0F, 8'h10);
    for (int k = 0; k < 20; k++)
      add(1, 1, 0, 0, 8'(8'h18 + k), 8, 0, 0, 8'(8'h10 + k), 8'(8'h11 + k));
    for (int j = 0; j < 8; j++) add(0, 1, 0, 0, 8'h00, 7 - j, 0, 0, 8'(8'h24 + j), 8'(8'h25 + j));
    // Full with simultaneous read/write, then clr_err alone and clr_err against a set.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'(8'h40 + i), i + 1, 0, 0, 8'h2B, 8'h40);
    add(1, 1, 0, 0, 8'h99, 15, 1, 0, 8'h40, 8'h41);
    add(0, 0, 0, 1, 8'h00, 15, 0, 0, 8'h40, 8'h41);
    add(1, 0, 0, 0, 8'h50, 16, 0, 0, 8'h40, 8'h41);
    add(1, 0, 0, 1, 8'hBB, 16, 1, 0, 8'h40, 8'h41);
    for (int j = 0; j < 16; j++) add(0, 1, 0, 0, 8'h00, 15 - j, 1, 0, 8'(8'h41 + j), 8'(8'h42 + j));
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h50, 8'h00);

    rst = 1'b0; wr_inc = 0; rd_inc = 0; flush = 0; clr_err = 0; d_input = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 0, 8'h00, 8'h00);
    rst = 1'b1;

    foreach (vecs[i]) run_vec("table", i, vecs[i]);

    // Flush at count 9 with a concurrent write, then a fresh write/read.
    for (int i = 0; i < 9; i++) begin
      v = '{1, 0, 0, 0, 8'(8'h60 + i), i + 1, 0, 0, 8'h50, 8'h60};
      run_vec("flush_fill", i, v);
    end
    v = '{1, 0, 1, 0, 8'h77, 0, 0, 0, 8'h50, 8'h00};
    run_vec("flush", 0, v);
    v = '{1, 0, 0, 0, 8'h5A, 1, 0, 0, 8'h50, 8'h5A};
    run_vec("flush_wr", 0, v);
    v = '{0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h5A, 8'h00};
    run_vec("flush_rd", 0, v);

    // Asynchronous reset between edges at count 9, with a pending overflow-free state.
    for (int i = 0; i < 9; i++) begin
      v = '{1, 0, 0, 0, 8'(8'h70 + i), i + 1, 0, 0, 8'h5A, 8'h70};
      run_vec("rst_fill", i, v);
    end
    wr_inc = 0; rd_inc = 0; flush = 0; clr_err = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state("rst_async", 0, 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    v = '{1, 0, 0, 0, 8'h33, 1, 0, 0, 8'h00, 8'h33};
    run_vec("rst_wr", 0, v);
    v = '{0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h33, 8'h00};
    run_vec("rst_rd", 0, v);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
